// File: rtl/lif_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lif_layer_scheduler
// Purpose  : Shares one leaky-integrate-and-fire datapath across a neuron
//            layer: saturating event accumulation, periodic threshold/decay sweep.
// Revision : 1.0 - initial release
// ============================================================================
module lif_layer_scheduler #(
    parameter int N_NEURONS    = 16,
    parameter int IDX_W        = 4,
    parameter int DATA_W       = 8,
    parameter int DECAY_PERIOD = 64,
    parameter int THRESH_INIT  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_idx,
    input  logic [DATA_W-1:0] in_weight,
    input  logic              thr_we,
    input  logic [DATA_W-1:0] thr_wdata,
    output logic              spk_valid,
    input  logic              spk_ready,
    output logic [IDX_W-1:0]  spk_idx,
    output logic              busy,
    output logic              overrun,
    output logic [15:0]       step_count
);

    localparam int                CNT_W       = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam logic [CNT_W-1:0]  c_tick_last = CNT_W'(DECAY_PERIOD - 1);
    localparam logic [IDX_W-1:0]  c_idx_last  = IDX_W'(N_NEURONS - 1);
    localparam logic [DATA_W-1:0] c_sat       = '1;
    localparam logic [DATA_W-1:0] c_thr_init  = DATA_W'(THRESH_INIT);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_tick_cnt;
    logic                r_sweep_pending;
    logic                r_overrun;
    logic [IDX_W-1:0]    r_ptr;
    logic [DATA_W-1:0]   r_thr;
    logic [DATA_W-1:0]   r_mem [N_NEURONS];
    logic                r_spk_valid;
    logic [IDX_W-1:0]    r_spk_idx;
    logic [15:0]         r_step_count;

    logic                w_tick;
    logic [DATA_W-1:0]   w_cur;
    logic                w_fire;
    logic                w_slot_free;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W-1:0]   w_sum_sat;
    logic                w_accept;
    logic                w_sweep_start;
    logic                w_advance;
    logic                w_load_spk;
    logic                w_sweep_end;

    assign w_tick      = (r_tick_cnt == c_tick_last);
    assign w_cur       = r_mem[r_ptr];
    assign w_fire      = (w_cur >= r_thr);
    assign w_slot_free = !r_spk_valid || spk_ready;
    assign w_sum       = {1'b0, r_mem[in_idx]} + {1'b0, in_weight};
    assign w_sum_sat   = w_sum[DATA_W] ? c_sat : w_sum[DATA_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A pending sweep blocks new events so the sweep sees a frozen layer.
    always_comb begin
        w_state_next  = r_state;
        in_ready      = 1'b0;
        w_accept      = 1'b0;
        w_sweep_start = 1'b0;
        w_advance     = 1'b0;
        w_load_spk    = 1'b0;
        w_sweep_end   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = reset && !r_sweep_pending;
                w_accept = in_valid && in_ready;
                if (r_sweep_pending) begin
                    w_state_next  = S_SWEEP;
                    w_sweep_start = 1'b1;
                end
            end
            S_SWEEP: begin
                if (w_fire) begin
                    if (w_slot_free) begin
                        w_load_spk = 1'b1;
                        w_advance  = 1'b1;
                    end
                end else begin
                    w_advance = 1'b1;
                end
                if (w_advance && (r_ptr == c_idx_last)) begin
                    w_sweep_end  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt      <= '0;
            r_sweep_pending <= 1'b0;
            r_overrun       <= 1'b0;
            r_ptr           <= '0;
            r_thr           <= c_thr_init;
            r_spk_valid     <= 1'b0;
            r_spk_idx       <= '0;
            r_step_count    <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_tick) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end

            // A tick landing on the sweep-start edge re-arms the pending flag.
            if (w_tick) begin
                r_sweep_pending <= 1'b1;
            end else if (w_sweep_start) begin
                r_sweep_pending <= 1'b0;
            end

            if (w_tick && (r_sweep_pending || (r_state == S_SWEEP))) begin
                r_overrun <= 1'b1;
            end

            if (thr_we) begin
                r_thr <= thr_wdata;
            end

            if (w_sweep_start) begin
                r_ptr <= '0;
            end else if (w_advance) begin
                r_ptr <= r_ptr + 1'b1;
            end

            if (w_accept) begin
                r_mem[in_idx] <= w_sum_sat;
            end
            if (w_advance) begin
                r_mem[r_ptr] <= w_fire ? '0 : (w_cur >> 1);
            end

            if (w_load_spk) begin
                r_spk_valid <= 1'b1;
                r_spk_idx   <= r_ptr;
            end else if (r_spk_valid && spk_ready) begin
                r_spk_valid <= 1'b0;
            end

            if (w_sweep_end) begin
                r_step_count <= r_step_count + 1'b1;
            end
        end
    end

    assign spk_valid  = r_spk_valid;
    assign spk_idx    = r_spk_idx;
    assign busy       = (r_state == S_SWEEP);
    assign overrun    = r_overrun;
    assign step_count = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_lif_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lif_layer_scheduler
// Purpose  : Vector table plus spike scoreboard against a per-sweep layer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lif_layer_scheduler;

    localparam int N = 16;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_idx;
    logic [7:0]  in_weight;
    logic        thr_we;
    logic [7:0]  thr_wdata;
    logic        spk_valid;
    logic        spk_ready;
    logic [3:0]  spk_idx;
    logic        busy;
    logic        overrun;
    logic [15:0] step_count;

    lif_layer_scheduler #(
        .N_NEURONS   (16),
        .IDX_W       (4),
        .DATA_W      (8),
        .DECAY_PERIOD(64),
        .THRESH_INIT (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .in_weight (in_weight),
        .thr_we    (thr_we),
        .thr_wdata (thr_wdata),
        .spk_valid (spk_valid),
        .spk_ready (spk_ready),
        .spk_idx   (spk_idx),
        .busy      (busy),
        .overrun   (overrun),
        .step_count(step_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int thr;
        int idx_a;
        int w_a;
        int idx_b;
        int w_b;
        int exp_n;
        int exp_first;
    } vec_t;

    vec_t vecs [8];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   model_st [N];
    int   model_thr;
    int   exp_steps;
    int   exp_q [$];
    int   spk_log [$];
    int   sb_sum;
    int   mark;
    logic busy_q = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_sweep();
        for (int p = 0; p < N; p++) begin
            if (model_st[p] >= model_thr) begin
                exp_q.push_back(p);
                model_st[p] = 0;
            end else begin
                model_st[p] = model_st[p] / 2;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) model_st[i] = 0;
        model_thr = 32;
        exp_steps = 0;
        exp_q.delete();
    endtask

    // Scoreboard: accepted events update the model, each sweep start pushes
    // the expected spike order, each spike handshake pops one entry.
    always @(negedge clk) begin
        if (!reset) begin
            busy_q = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                sb_sum = model_st[in_idx] + int'(in_weight);
                model_st[in_idx] = (sb_sum > 255) ? 255 : sb_sum;
            end
            if (spk_valid && spk_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spike_unexpected: got idx %0d, expected no spike (cycle %0d)", spk_idx, cyc);
                end else begin
                    chk("spike_idx", int'(spk_idx), exp_q.pop_front());
                end
                spk_log.push_back(int'(spk_idx));
            end
            if (busy && !busy_q) model_sweep();
            if (!busy && busy_q) begin
                exp_steps = (exp_steps + 1) % 65536;
                chk("step_count", int'(step_count), exp_steps);
            end
            busy_q = busy;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_busy(input logic val, input int budget);
        for (int k = 0; k < budget && busy !== val; k++) step();
        if (busy !== val) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_busy_timeout: got busy=%0d, expected %0d (cycle %0d)", busy, val, cyc);
        end
    endtask

    task automatic wait_spk(input int budget);
        for (int k = 0; k < budget && spk_valid !== 1'b1; k++) step();
        chk("wait_spk_valid", int'(spk_valid), 1);
    endtask

    task automatic sweep_done();
        wait_busy(1'b1, 200);
        wait_busy(1'b0, 200);
        steps(2);
    endtask

    task automatic set_thr(input int v);
        thr_wdata = 8'(v);
        thr_we    = 1'b1;
        step();
        thr_we    = 1'b0;
        model_thr = v;
    endtask

    // Leaves in_valid high so consecutive calls issue back-to-back events.
    task automatic send(input int idx, input int w);
        bit done = 0;
        in_idx    = 4'(idx);
        in_weight = 8'(w);
        in_valid  = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            if (in_ready) done = 1;
            step();
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0, expected 1 (cycle %0d)", cyc);
        end
    endtask

    task automatic clear_all();
        set_thr(0);
        sweep_done();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish by 1ms");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_idx    = '0;
        in_weight = '0;
        thr_we    = 1'b0;
        thr_wdata = '0;
        spk_ready = 1'b1;
        model_reset();

        vecs[0] = '{32,  3, 20,  3, 20,  1,  3};
        vecs[1] = '{32,  5, 20,  5,  0,  0,  0};
        vecs[2] = '{255, 7, 250, 7, 250, 1,  7};
        vecs[3] = '{32,  0, 31, 15, 32,  1, 15};
        vecs[4] = '{32, 15, 200, 0, 33,  2,  0};
        vecs[5] = '{1,   8,  1,  9,  0,  1,  8};
        vecs[6] = '{0,   2,  0,  2,  0, 16,  0};
        vecs[7] = '{128, 6, 127, 6,  1,  1,  6};

        steps(3);
        chk("rst_in_ready",   int'(in_ready),   0);
        chk("rst_spk_valid",  int'(spk_valid),  0);
        chk("rst_spk_idx",    int'(spk_idx),    0);
        chk("rst_busy",       int'(busy),       0);
        chk("rst_overrun",    int'(overrun),    0);
        chk("rst_step_count", int'(step_count), 0);

        // Idle timing: tick at edge 64, sweep busy after edges 65..80.
        reset = 1'b1;
        cyc   = 0;
        for (int e = 1; e <= 81; e++) begin
            step();
            chk("idle_busy",      int'(busy),      (e >= 65 && e <= 80) ? 1 : 0);
            chk("idle_spk_valid", int'(spk_valid), 0);
            chk("idle_in_ready",  int'(in_ready),  (e >= 64 && e <= 80) ? 0 : 1);
        end

        for (int i = 0; i < 8; i++) begin
            clear_all();
            set_thr(vecs[i].thr);
            send(vecs[i].idx_a, vecs[i].w_a);
            send(vecs[i].idx_b, vecs[i].w_b);
            in_valid = 1'b0;
            mark = spk_log.size();
            sweep_done();
            chk("vec_spike_count", spk_log.size() - mark, vecs[i].exp_n);
            if (vecs[i].exp_n > 0) chk("vec_first_idx", spk_log[mark], vecs[i].exp_first);
        end

        // Leak: 20 -> 10 -> 5 across consecutive sweeps.
        clear_all();
        set_thr(32);
        send(5, 20);
        in_valid = 1'b0;
        mark = spk_log.size();
        sweep_done();
        chk("leak_sweep1_spikes", spk_log.size() - mark, 0);
        set_thr(11);
        mark = spk_log.size();
        sweep_done();
        chk("leak_sweep2_spikes", spk_log.size() - mark, 0);
        set_thr(5);
        mark = spk_log.size();
        sweep_done();
        chk("leak_sweep3_spikes", spk_log.size() - mark, 1);
        chk("leak_sweep3_idx", spk_log[mark], 5);

        // Backpressure stall on the second firing neuron.
        clear_all();
        set_thr(32);
        send(1, 40);
        send(2, 40);
        in_valid  = 1'b0;
        spk_ready = 1'b0;
        mark = spk_log.size();
        wait_busy(1'b1, 200);
        wait_spk(20);
        chk("stall_first_idx", int'(spk_idx), 1);
        steps(16);
        chk("stall_hold_valid", int'(spk_valid), 1);
        chk("stall_hold_idx",   int'(spk_idx),   1);
        chk("stall_busy",       int'(busy),      1);
        spk_ready = 1'b1;
        wait_busy(1'b0, 200);
        steps(2);
        chk("stall_spike_count", spk_log.size() - mark, 2);

        // Stall across a tick -> sticky overrun.
        chk("overrun_before", int'(overrun), 0);
        clear_all();
        set_thr(32);
        send(1, 40);
        send(2, 40);
        in_valid  = 1'b0;
        spk_ready = 1'b0;
        wait_busy(1'b1, 200);
        steps(70);
        chk("overrun_set",          int'(overrun), 1);
        chk("overrun_stalled_busy", int'(busy),    1);
        spk_ready = 1'b1;
        wait_busy(1'b0, 200);
        sweep_done();
        sweep_done();
        chk("overrun_sticky", int'(overrun), 1);

        // Raised threshold suppresses spikes.
        set_thr(100);
        send(4, 50);
        send(11, 50);
        in_valid = 1'b0;
        mark = spk_log.size();
        sweep_done();
        chk("thr100_spikes", spk_log.size() - mark, 0);

        // Asynchronous reset in the middle of a sweep with a spike pending.
        set_thr(32);
        send(3, 40);
        send(9, 30);
        in_valid  = 1'b0;
        spk_ready = 1'b0;
        wait_busy(1'b1, 200);
        wait_spk(20);
        chk("pre_reset_spk_idx", int'(spk_idx), 3);
        reset = 1'b0;
        #1;
        chk("mid_rst_spk_valid",  int'(spk_valid),  0);
        chk("mid_rst_spk_idx",    int'(spk_idx),    0);
        chk("mid_rst_busy",       int'(busy),       0);
        chk("mid_rst_overrun",    int'(overrun),    0);
        chk("mid_rst_step_count", int'(step_count), 0);
        chk("mid_rst_in_ready",   int'(in_ready),   0);
        model_reset();
        spk_ready = 1'b1;
        steps(3);
        reset = 1'b1;
        mark = spk_log.size();
        send(9, 10);
        in_valid = 1'b0;
        sweep_done();
        chk("post_rst_no_retained", spk_log.size() - mark, 0);
        mark = spk_log.size();
        send(9, 27);
        in_valid = 1'b0;
        sweep_done();
        chk("post_rst_spike_count", spk_log.size() - mark, 1);

        chk("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lif_layer_scheduler.md
Name: lif_layer_scheduler

Overview:
- Time-multiplexes one leaky-integrate-and-fire update datapath over N_NEURONS neurons held in an internal state register file.
- Accepts synaptic events (neuron index + weight) over a valid/ready handshake.
- A periodic internal decay tick triggers a sweep: every neuron is compared to threshold, then either fires and clears, or halves.
- Fired neuron indices leave on a valid/ready spike stream. Sits between the synapse/crossbar front end and the spike router; replaces per-neuron decay clocks with one clock-domain scheduler.

Parameters:
N_NEURONS, 16, neurons in the layer (power of two, >=2)
IDX_W, 4, neuron index width, log2(N_NEURONS)
DATA_W, 8, membrane state and weight width (unsigned)
DECAY_PERIOD, 64, clk cycles between decay ticks (>= N_NEURONS+2)
THRESH_INIT, 32, threshold value after reset

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low; clears all state
in_valid  input  1  synaptic event valid
in_ready  output  1  scheduler can accept an event this cycle
in_idx  input  IDX_W  target neuron
in_weight  input  DATA_W  unsigned weight to add
thr_we  input  1  threshold write strobe
thr_wdata  input  DATA_W  new threshold
spk_valid  output  1  spike event valid
spk_ready  input  1  downstream accepts spike
spk_idx  output  IDX_W  index of fired neuron
busy  output  1  high while in SWEEP
overrun  output  1  sticky; a tick arrived while a sweep was still pending/active
step_count  output  16  completed sweeps, wraps at 2^16

Behaviour:
- Reset (reset=0, async): all neuron states=0; threshold=THRESH_INIT; tick counter=0; FSM=IDLE; sweep_pending=0. Outputs: spk_valid=0, spk_idx=0, busy=0, overrun=0, step_count=0, in_ready=0 while reset asserted.
- Tick counter: free-runs 0..DECAY_PERIOD-1 in every state. At terminal count it wraps and sets sweep_pending. If sweep_pending is already 1 or the FSM is in SWEEP at that edge, overrun sets. Overrun clears only on reset.
- FSM states: IDLE and SWEEP.
- IDLE:
  - in_ready = !sweep_pending.
  - On in_valid&&in_ready: state[in_idx] <= min(state[in_idx]+in_weight, 2^DATA_W-1), saturating, visible next cycle.
  - If sweep_pending=1, go to SWEEP next cycle, clear sweep_pending, sweep pointer p=0. Sweep has priority over new inputs.
  - Back-to-back events to the same index accumulate correctly, one per cycle.
- SWEEP:
  - in_ready=0; busy=1.
  - Each cycle, evaluate neuron p against the current threshold:
    - state[p] >= thr and spike slot free (spk_valid=0 or spk_ready=1): spk_valid<=1, spk_idx<=p, state[p]<=0, p++.
    - state[p] >= thr and slot blocked (spk_valid=1 and spk_ready=0): stall; p, state and spk outputs hold.
    - state[p] < thr: state[p] <= state[p]>>1; p++; spike register drops valid if accepted (spk_ready=1).
  - After p=N_NEURONS-1 advances: step_count++, go to IDLE.
  - Uncongested sweep takes exactly N_NEURONS cycles.
- Spike output register: spk_valid/spk_idx stable while spk_valid=1 and spk_ready=0. Cleared on handshake unless reloaded the same cycle.
- Threshold:
  - thr_we loads thr_wdata at the edge, in any state; the new value is used from the next cycle's comparison.
  - thr_wdata=0 makes every neuron fire each sweep.
- Simultaneous tick and input handshake in IDLE: the input is applied first (same edge); the sweep starts the cycle after and sees the updated state.
- Reset mid-sweep: immediate abort; no partial state retained; any pending spike is dropped.

Test Plan:
- Reset then idle 64 cycles, DECAY_PERIOD=64 -> spk_valid=0 throughout; busy high for cycles 65..80 (16 cycles); step_count=1; all states 0.
- Inputs idx=3 w=20, then idx=3 w=20, before the first tick -> the sweep emits exactly one spike, spk_idx=3; state[3]=0; with spk_ready=1, no stall.
- idx=5 w=20 only -> no spike; state[5]=10 after sweep 1, 5 after sweep 2.
- idx=7 w=250, idx=7 w=250 -> state[7]=255 (saturated), not 244; the sweep spikes idx 7.
- Neurons 1 and 2 above threshold, spk_ready=0 for 10 cycles during the sweep -> spk_idx=1 held stable; the sweep stalls at p=2; after release, spikes 1 then 2 arrive in order; step_count increments once.
- Hold spk_ready=0 for more than DECAY_PERIOD cycles with a spike pending -> overrun=1 and stays 1. thr_we=1 thr_wdata=100 then inputs of 50 -> no spike. Assert reset mid-sweep -> all outputs return to reset values immediately.
